// File: rtl/mul_float_pipe.sv
// mul_float_pipe: three-stage pipelined floating-point multiplier with
// valid/ready handshakes, round-to-nearest-even, special-value handling and
// per-result {invalid, overflow, underflow} flags. Denormals flush to zero.
module mul_float_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [2:0]   flags
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * (MAN_W + 1);
  localparam logic signed [EW2-1:0] BIAS_S    = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ZERO_S    = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // stage 1 registers: unpacked operands
  logic                  s1_v_q, s1_v_d;
  logic                  s1_sign_q, s1_sign_d;
  logic signed [EW2-1:0] s1_exp_q, s1_exp_d;
  logic [PW-1:0]         s1_prod_q, s1_prod_d;
  logic                  s1_spec_q, s1_spec_d;
  logic [W-1:0]          s1_spec_y_q, s1_spec_y_d;
  logic                  s1_inv_q, s1_inv_d;
  // stage 2 registers: normalised mantissa with guard/round/sticky
  logic                  s2_v_q, s2_v_d;
  logic                  s2_sign_q, s2_sign_d;
  logic signed [EW2-1:0] s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0]      s2_frac_q, s2_frac_d;
  logic                  s2_g_q, s2_g_d;
  logic                  s2_r_q, s2_r_d;
  logic                  s2_s_q, s2_s_d;
  logic                  s2_spec_q, s2_spec_d;
  logic [W-1:0]          s2_spec_y_q, s2_spec_y_d;
  logic                  s2_inv_q, s2_inv_d;
  // stage 3 registers: the visible result
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          y_q, y_d;
  logic [2:0]            flags_q, flags_d;

  logic advance;

  // the whole pipe moves as one unless a finished result is stuck at the output
  always_comb begin
    advance  = !out_valid_q || out_ready;
    in_ready = advance;
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flags     = flags_q;

  // stage 1: unpack, classify, exponent sum, mantissa product
  always_comb begin
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    sa = a[W-1];
    sb = b[W-1];
    ea = a[W-2:MAN_W];
    eb = b[W-2:MAN_W];
    fa = a[MAN_W-1:0];
    fb = b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);

    s1_v_d      = s1_v_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_prod_d   = s1_prod_q;
    s1_spec_d   = s1_spec_q;
    s1_spec_y_d = s1_spec_y_q;
    s1_inv_d    = s1_inv_q;
    if (advance) begin
      s1_v_d      = in_valid;
      s1_sign_d   = sa ^ sb;
      s1_exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
      s1_prod_d   = PW'({1'b1, fa}) * PW'({1'b1, fb});
      s1_spec_d   = 1'b0;
      s1_spec_y_d = '0;
      s1_inv_d    = 1'b0;
      if (a_nan || b_nan) begin
        s1_spec_d   = 1'b1;
        s1_spec_y_d = QNAN;
      end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
        s1_spec_d   = 1'b1;
        s1_spec_y_d = QNAN;
        s1_inv_d    = 1'b1;
      end else if (a_inf || b_inf) begin
        s1_spec_d   = 1'b1;
        s1_spec_y_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
        s1_spec_d   = 1'b1;
        s1_spec_y_d = {sa ^ sb, {(W-1){1'b0}}};
      end
    end
  end

  // stage 2: normalise a product in [1,4) to [1,2) and split off guard/round/sticky
  always_comb begin
    logic [PW-2:0] norm;
    norm = s1_prod_q[PW-1] ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};

    s2_v_d      = s2_v_q;
    s2_sign_d   = s2_sign_q;
    s2_exp_d    = s2_exp_q;
    s2_frac_d   = s2_frac_q;
    s2_g_d      = s2_g_q;
    s2_r_d      = s2_r_q;
    s2_s_d      = s2_s_q;
    s2_spec_d   = s2_spec_q;
    s2_spec_y_d = s2_spec_y_q;
    s2_inv_d    = s2_inv_q;
    if (advance) begin
      s2_v_d      = s1_v_q;
      s2_sign_d   = s1_sign_q;
      s2_exp_d    = s1_exp_q + $signed(EW2'(s1_prod_q[PW-1]));
      s2_frac_d   = norm[PW-2 -: MAN_W];
      s2_g_d      = norm[PW-2-MAN_W];
      s2_r_d      = norm[PW-3-MAN_W];
      s2_s_d      = |norm[PW-4-MAN_W:0];
      s2_spec_d   = s1_spec_q;
      s2_spec_y_d = s1_spec_y_q;
      s2_inv_d    = s1_inv_q;
    end
  end

  // stage 3: round to nearest even, range check, pick special or arithmetic result
  always_comb begin
    logic                  inc;
    logic [MAN_W:0]        rnd;
    logic signed [EW2-1:0] exp_f;
    inc   = s2_g_q && (s2_r_q || s2_s_q || s2_frac_q[0]);
    rnd   = {1'b0, s2_frac_q} + (MAN_W+1)'(inc);
    // a carry out means 1.11..1 rounded up to 10.00..0: fraction is already zero
    exp_f = s2_exp_q + $signed(EW2'(rnd[MAN_W]));

    out_valid_d = out_valid_q;
    y_d         = y_q;
    flags_d     = flags_q;
    if (advance) begin
      out_valid_d = s2_v_q;
      if (s2_spec_q) begin
        y_d     = s2_spec_y_q;
        flags_d = {s2_inv_q, 2'b00};
      end else if (exp_f >= EXP_MAX_S) begin
        y_d     = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d = 3'b010;
      end else if (exp_f <= ZERO_S) begin
        y_d     = {s2_sign_q, {(W-1){1'b0}}};
        flags_d = 3'b001;
      end else begin
        y_d     = {s2_sign_q, exp_f[EXP_W-1:0], rnd[MAN_W-1:0]};
        flags_d = 3'b000;
      end
    end
  end

  // pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_prod_q   <= '0;
      s1_spec_q   <= 1'b0;
      s1_spec_y_q <= '0;
      s1_inv_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      s2_g_q      <= 1'b0;
      s2_r_q      <= 1'b0;
      s2_s_q      <= 1'b0;
      s2_spec_q   <= 1'b0;
      s2_spec_y_q <= '0;
      s2_inv_q    <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_prod_q   <= s1_prod_d;
      s1_spec_q   <= s1_spec_d;
      s1_spec_y_q <= s1_spec_y_d;
      s1_inv_q    <= s1_inv_d;
      s2_v_q      <= s2_v_d;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      s2_g_q      <= s2_g_d;
      s2_r_q      <= s2_r_d;
      s2_s_q      <= s2_s_d;
      s2_spec_q   <= s2_spec_d;
      s2_spec_y_q <= s2_spec_y_d;
      s2_inv_q    <= s2_inv_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_mul_float_pipe.sv
// Scoreboard bench for mul_float_pipe (single precision).
module tb_mul_float_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  mul_float_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  typedef struct {
    logic [31:0] y;
    logic [2:0]  f;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [2:0]  f;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_recv  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // monitor: pops and compares on every result transfer, and watches stalls
  logic        stall_prev = 1'b0;
  logic [31:0] y_prev;
  logic [2:0]  f_prev;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_y", 64'(y), 64'(y_prev));
          chk("stall_flags", 64'(flags), 64'(f_prev));
        end
        if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got y=%h flags=%b, expected nothing", y, flags);
          end else begin
            e = sb.pop_front();
            chk("y", 64'(y), 64'(e.y));
            chk("flags", 64'(flags), 64'(e.f));
            if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
            n_recv++;
          end
        end
        stall_prev = out_valid && !out_ready;
        y_prev     = y;
        f_prev     = flags;
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the operand was taken
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ey, input logic [2:0] ef, input bit lat);
    int   t;
    exp_t e;
    t = 0;
    a = ia;
    b = ib;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      timeout_fail("issue_accept");
    end else begin
      e.y = ey;
      e.f = ef;
      e.cyc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18] = '{
    '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000},
    '{32'h3F800000, 32'hBF000000, 32'hBF000000, 3'b000},
    '{32'h3F800001, 32'h40400000, 32'h40400002, 3'b000},
    '{32'h7E967699, 32'h7E967699, 32'h7F800000, 3'b010},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b001},
    '{32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b000},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000},
    '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000},
    '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000},
    '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000},
    '{32'hC0000000, 32'hC0400000, 32'h40C00000, 3'b000},
    '{32'h7F800000, 32'h80000000, 32'h7FC00000, 3'b100},
    '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 3'b000},
    '{32'h80800000, 32'h3F000000, 32'h80000000, 3'b001},
    '{32'hFE967699, 32'h7E967699, 32'hFF800000, 3'b010}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int recv0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // isolated directed vectors, latency checked on each
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].f, 1'b1);
      drain();
    end

    // six back-to-back ops with the consumer stalled for five cycles
    recv0 = n_recv;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].f, 1'b0);
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (!out_valid) timeout_fail("stream_first_valid");
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(n_recv - recv0), 64'd6);

    // reset with two ops in flight and a result waiting at the output
    out_ready = 1'b0;
    issue(vecs[12].a, vecs[12].b, vecs[12].y, vecs[12].f, 1'b0);
    issue(vecs[13].a, vecs[13].b, vecs[13].y, vecs[13].f, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!out_valid) timeout_fail("reset_test_valid");
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_y", 64'(y), 64'd0);
    chk("midreset_flags", 64'(flags), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    chk("postreset_in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("postreset_out_valid", 64'(out_valid), 64'd0);

    // pipeline still works after the mid-stream reset
    issue(vecs[2].a, vecs[2].b, vecs[2].y, vecs[2].f, 1'b1);
    drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
